// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: E-stage issue/stall control in front of the multiply/divide unit
module md_issue_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             IntReq,
    input  logic [3:0]       D_md_op,
    input  logic [31:0]      D_rs,
    input  logic [31:0]      D_rt,
    output logic [7:0]       E_ALUop,
    output logic [31:0]      E_regA,
    output logic [31:0]      E_regB,
    output logic [1:0]       E_mf_sel,
    output logic             stall,
    output logic [CNT_W-1:0] busy_cnt,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, MULT_RUN, DIV_RUN} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt_n;
    logic             done_n;
    logic             d_is_md, e_start, issue;
    logic [7:0]       alu_n;
    logic [1:0]       mf_n;

    // Hazard detection: an MD op in D must wait while the unit is starting or running
    always_comb begin
        d_is_md = (D_md_op >= 4'd1) && (D_md_op <= 4'd8);
        e_start = (E_ALUop >= 8'd24) && (E_ALUop <= 8'd27) && !IntReq;
        stall   = d_is_md && ((state != IDLE) || e_start);
        issue   = d_is_md && !stall && !IntReq;
    end

    // Decode the D-stage MD op into the unit opcode and the HI/LO read select
    always_comb begin
        alu_n = 8'd0;
        mf_n  = 2'b00;
        case (D_md_op)
            4'd1: alu_n = 8'd24;
            4'd2: alu_n = 8'd25;
            4'd3: alu_n = 8'd26;
            4'd4: alu_n = 8'd27;
            4'd5: alu_n = 8'd28;
            4'd6: alu_n = 8'd29;
            4'd7: mf_n  = 2'b01;
            4'd8: mf_n  = 2'b10;
            default: ;
        endcase
    end

    // D->E pipeline register; interrupts and stalls insert an all-zero bubble
    always_ff @(posedge clk) begin
        if (reset || !issue) begin
            E_ALUop  <= 8'd0;
            E_mf_sel <= 2'b00;
            E_regA   <= 32'd0;
            E_regB   <= 32'd0;
        end else begin
            E_ALUop  <= alu_n;
            E_mf_sel <= mf_n;
            E_regA   <= D_rs;
            E_regB   <= D_rt;
        end
    end

    // Busy tracker next state: loads the unit latency on start, counts down, pulses done
    always_comb begin
        state_n = state;
        cnt_n   = busy_cnt;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (e_start) begin
                    state_n = (E_ALUop < 8'd26) ? MULT_RUN : DIV_RUN;
                    cnt_n   = (E_ALUop < 8'd26) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                end
            end
            default: begin
                if (busy_cnt > CNT_W'(1)) begin
                    cnt_n = busy_cnt - CNT_W'(1);
                end else begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    done_n  = 1'b1;
                end
            end
        endcase
    end

    // Busy tracker state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy_cnt <= '0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            busy_cnt <= cnt_n;
            done     <= done_n;
        end
    end
endmodule
